sva_window_monitor: RTL

Synthesizable runtime checker for bounded SVA-style property windows: each cycle the antecedent holds, it opens an attempt requiring the consequent to hold on every cycle (ALWAYS) or on at least one cycle (EVENTUALLY) within a delay window [LO:HI]. It tracks all overlapping attempts in flight and reports per-cycle pass/fail counts. It sits directly downstream of the assertion-test stimulus logic and consumes its antecedent/consequent signals. The bench uses it as a cycle-exact golden model for `always`/`s_always`/`eventually`/`s_eventually` results.

---
 rtl/sva_mon_pkg.sv | 33 +++
 rtl/sva_window_popcnt.sv | 25 ++
 rtl/sva_window_monitor.sv | 132 +++++++++++++
 3 files changed

// File: rtl/sva_mon_pkg.sv
// Shared definitions for the bounded property-window monitor.
//   mode_e    : window check flavour (every cycle vs. at least one cycle)
//   TOTAL_W   : width of the cumulative pass/fail accumulators
//   POP_W     : widest retire vector the popcount helper accepts (HI <= 63)
//   popcount  : number of set bits in a POP_W-wide vector
//   sat_add   : accumulator add that clamps at all-ones instead of wrapping
package sva_mon_pkg;

   typedef enum logic {
      MODE_ALWAYS     = 1'b0,
      MODE_EVENTUALLY = 1'b1
   } mode_e;

   localparam int TOTAL_W = 32;
   localparam int POP_W   = 64;

   function automatic logic [6:0] popcount(input logic [POP_W-1:0] vec);
      logic [6:0] n;
      n = '0;
      for (int i = 0; i < POP_W; i++) begin
         n = n + 7'(vec[i]);
      end
      return n;
   endfunction

   function automatic logic [TOTAL_W-1:0] sat_add(input logic [TOTAL_W-1:0] acc,
                                                   input logic [6:0]         inc);
      logic [TOTAL_W:0] sum;
      sum = {1'b0, acc} + {{(TOTAL_W-6){1'b0}}, inc};
      return sum[TOTAL_W] ? {TOTAL_W{1'b1}} : sum[TOTAL_W-1:0];
   endfunction

endpackage

// File: rtl/sva_window_popcnt.sv
// Combinational population count of one retire vector.
//   vec_i : W-bit retire vector (one bit per attempt age)
//   cnt_o : number of set bits, CW bits wide (max value W)
module sva_window_popcnt
   import sva_mon_pkg::*;
#(
   parameter int W  = 6,
   parameter int CW = 3
)
(
   input  logic [W-1:0]  vec_i,
   output logic [CW-1:0] cnt_o
);

   logic [POP_W-1:0] vec_ext;
   logic [6:0]       cnt_full;

   always_comb begin
      vec_ext          = '0;
      vec_ext[W-1:0]   = vec_i;
      cnt_full         = popcount(vec_ext);
      cnt_o            = cnt_full[CW-1:0];
   end

endmodule

// File: rtl/sva_window_monitor.sv
// Runtime checker for bounded property windows [LO:HI]. Every edge with a_i
// high opens an attempt; each attempt must see b_i on every window cycle
// (MODE=0) or on at least one window cycle (MODE=1). Overlapping attempts are
// tracked as an age vector and resolved verdicts are reported as per-edge
// population counts.
//
// Optional feature: define SVA_WINDOW_MONITOR_TOTALS_EN to build the 32-bit
// saturating pass/fail accumulators; otherwise the total outputs read 0.
//
// Ports:
//   clk          : clock, all state on posedge
//   rst_n        : asynchronous active-low reset
//   a_i          : antecedent, starts an attempt at the edge
//   b_i          : consequent, sampled every edge
//   final_i      : end-of-test, resolves every attempt still pending
//   pass_cnt_o   : attempts passing at the previous edge
//   fail_cnt_o   : attempts failing at the previous edge
//   pending_o    : at least one attempt still in flight
//   pass_total_o : cumulative passes (saturating)
//   fail_total_o : cumulative fails (saturating)
module sva_window_monitor
   import sva_mon_pkg::*;
#(
   parameter int LO     = 0,
   parameter int HI     = 5,
   parameter int MODE   = 0,
   parameter int STRONG = 0
)
(
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      a_i,
   input  logic                      b_i,
   input  logic                      final_i,
   output logic [$clog2(HI+2)-1:0]   pass_cnt_o,
   output logic [$clog2(HI+2)-1:0]   fail_cnt_o,
   output logic                      pending_o,
   output logic [TOTAL_W-1:0]        pass_total_o,
   output logic [TOTAL_W-1:0]        fail_total_o
);

   localparam int    CW       = $clog2(HI+2);
   localparam mode_e MODE_E   = (MODE != 0) ? MODE_EVENTUALLY : MODE_ALWAYS;
   localparam bit    STRONG_B = (STRONG != 0);

   // live_q[k] holds an attempt that will be age k at the next edge; age 0 is
   // always the incoming a_i, so no storage is needed for it.
   logic [HI:1]   live_q, live_d;
   logic [HI:0]   cur, pass_v, fail_v, survive, fail_all;
   logic [CW-1:0] pass_cnt_q, pass_cnt_d;
   logic [CW-1:0] fail_cnt_q, fail_cnt_d;
   logic          pending_q, pending_d;

   always_comb begin
      cur    = {live_q, a_i};
      pass_v = '0;
      fail_v = '0;
      for (int k = 0; k <= HI; k++) begin
         if (k >= LO) begin
            if (MODE_E == MODE_ALWAYS) begin
               fail_v[k] = cur[k] & ~b_i;
               pass_v[k] = cur[k] & b_i & (k == HI);
            end else begin
               pass_v[k] = cur[k] & b_i;
               fail_v[k] = cur[k] & ~b_i & (k == HI);
            end
         end
      end
      survive  = cur & ~pass_v & ~fail_v;
      // Attempts cut short by final_i only count when the property is strong.
      fail_all = fail_v | ((final_i && STRONG_B) ? survive : '0);
      live_d   = final_i ? '0 : survive[HI-1:0];
      pending_d = |live_d;
   end

   sva_window_popcnt #(.W(HI+1), .CW(CW)) u_pass_pc (
      .vec_i (pass_v),
      .cnt_o (pass_cnt_d)
   );

   sva_window_popcnt #(.W(HI+1), .CW(CW)) u_fail_pc (
      .vec_i (fail_all),
      .cnt_o (fail_cnt_d)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         live_q     <= '0;
         pass_cnt_q <= '0;
         fail_cnt_q <= '0;
         pending_q  <= 1'b0;
      end else begin
         live_q     <= live_d;
         pass_cnt_q <= pass_cnt_d;
         fail_cnt_q <= fail_cnt_d;
         pending_q  <= pending_d;
      end
   end

   assign pass_cnt_o = pass_cnt_q;
   assign fail_cnt_o = fail_cnt_q;
   assign pending_o  = pending_q;

`ifdef SVA_WINDOW_MONITOR_TOTALS_EN
   logic [TOTAL_W-1:0] pass_total_q, pass_total_d;
   logic [TOTAL_W-1:0] fail_total_q, fail_total_d;

   // Totals include the verdicts of the same edge, so they move together with
   // the count outputs.
   always_comb begin
      pass_total_d = sat_add(pass_total_q, 7'(pass_cnt_d));
      fail_total_d = sat_add(fail_total_q, 7'(fail_cnt_d));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pass_total_q <= '0;
         fail_total_q <= '0;
      end else begin
         pass_total_q <= pass_total_d;
         fail_total_q <= fail_total_d;
      end
   end

   assign pass_total_o = pass_total_q;
   assign fail_total_o = fail_total_q;
`else
   assign pass_total_o = '0;
   assign fail_total_o = '0;
`endif

endmodule
